// File: rtl/counter_sequence_checker.sv
// Receive-side monitor for an up/down counter: classifies each sampled
// transition, locks onto the commanded direction and latches faults.
module counter_sequence_checker #(
    parameter int WIDTH     = 3,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     q_in,
    input  logic                 mod_in,
    input  logic                 clr_fault,
    output logic                 locked,
    output logic                 fault,
    output logic                 step_up,
    output logic                 step_dn,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     prev_q_q, prev_q_d;
    logic                 prev_mod_q, prev_mod_d;
    logic [3:0]           match_cnt_q, match_cnt_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 step_up_q, step_up_d;
    logic                 step_dn_q, step_dn_d;
    logic                 err_q, err_d;

    logic [WIDTH-1:0] q_inc, q_dec;
    logic [3:0]       match_inc;
    logic             is_hold, is_up, is_dn, is_good, is_bad;

    // Modulo arithmetic falls out of the WIDTH-bit truncation.
    assign q_inc     = prev_q_q + 1'b1;
    assign q_dec     = prev_q_q - 1'b1;
    assign match_inc = match_cnt_q + 4'd1;
    assign is_hold   = (q_in == prev_q_q);
    assign is_up     = (q_in == q_inc);
    assign is_dn     = (q_in == q_dec);
    assign is_good   = (is_up && prev_mod_q) || (is_dn && !prev_mod_q);
    assign is_bad    = !is_hold && !is_good;

    always_comb begin
        state_d     = state_q;
        prev_q_d    = prev_q_q;
        prev_mod_d  = prev_mod_q;
        match_cnt_d = match_cnt_q;
        err_count_d = err_count_q;
        step_up_d   = 1'b0;
        step_dn_d   = 1'b0;
        err_d       = 1'b0;

        if (sample_en) begin
            prev_q_d   = q_in;
            prev_mod_d = mod_in;
            if (state_q != ST_IDLE) begin
                step_up_d = is_up;
                step_dn_d = is_dn;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_ACQUIRE;
                    match_cnt_d = 4'd0;
                end
                ST_ACQUIRE: begin
                    if (is_good) begin
                        if (match_inc == LOCK_TGT) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = 4'd0;
                        end else begin
                            match_cnt_d = match_inc;
                        end
                    end else if (is_bad) begin
                        match_cnt_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (is_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_FAULT;
                        if (err_count_q != {ERR_CNT_W{1'b1}})
                            err_count_d = err_count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // The acknowledge overrides whatever the classification decided.
        if (state_q == ST_FAULT && clr_fault) begin
            state_d     = ST_ACQUIRE;
            match_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            prev_q_q    <= '0;
            prev_mod_q  <= 1'b0;
            match_cnt_q <= 4'd0;
            err_count_q <= '0;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q_q    <= prev_q_d;
            prev_mod_q  <= prev_mod_d;
            match_cnt_q <= match_cnt_d;
            err_count_q <= err_count_d;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
            err_q       <= err_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign fault     = (state_q == ST_FAULT);
    assign step_up   = step_up_q;
    assign step_dn   = step_dn_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
